// File: rtl/ex_mem_stage.sv
// Memory stage of the 64-bit RISC-V pipeline: EX/MEM register, doubleword data memory,
// branch resolution and the MEM/WB register feeding write-back.
module ex_mem_stage #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [63:0] ALU_result,
  input  logic [63:0] B,
  input  logic [63:0] Target,
  input  logic        Zero,
  input  logic [4:0]  rd,
  input  logic        Branch,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  output logic        PCSrc,
  output logic [63:0] Branch_target,
  output logic [4:0]  EXMEM_rd,
  output logic        EXMEM_RegWrite,
  output logic [63:0] EXMEM_ALU_result,
  output logic [63:0] WB_data,
  output logic [4:0]  WB_rd,
  output logic        WB_RegWrite,
  output logic        misaligned
);

  // EX/MEM register
  logic        branch_q, memread_q, memwrite_q, memtoreg_q, regwrite_q, zero_q;
  logic [63:0] alu_q, b_q, target_q;
  logic [4:0]  rd_q;

  // MEM/WB register
  logic [63:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        wb_regwrite_q, wb_mis_q;

  logic [63:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic          mis;
  logic          mem_we;
  logic [63:0]   rdata;
  logic [63:0]   wb_data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      zero_q     <= 1'b0;
      alu_q      <= '0;
      b_q        <= '0;
      target_q   <= '0;
      rd_q       <= '0;
    end else if (!stall) begin
      // A flush keeps the data fields but turns the slot into a bubble.
      branch_q   <= Branch   & ~flush;
      memread_q  <= MemRead  & ~flush;
      memwrite_q <= MemWrite & ~flush;
      memtoreg_q <= MemtoReg & ~flush;
      regwrite_q <= RegWrite & ~flush;
      zero_q     <= Zero;
      alu_q      <= ALU_result;
      b_q        <= B;
      target_q   <= Target;
      rd_q       <= rd;
    end
  end

  always_comb begin
    idx       = alu_q[AW+2:3];
    mis       = (memread_q | memwrite_q) & (alu_q[2:0] != 3'd0);
    mem_we    = memwrite_q & ~mis & ~stall;
    rdata     = mem_q[idx];
    wb_data_d = memtoreg_q ? (mis ? '0 : rdata) : alu_q;
  end

  // Memory contents survive reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[idx] <= b_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_mis_q      <= 1'b0;
    end else if (!stall) begin
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= rd_q;
      wb_regwrite_q <= regwrite_q & ~(memread_q & mis);
      wb_mis_q      <= mis;
    end
  end

  always_comb begin
    PCSrc            = branch_q & zero_q;
    Branch_target    = target_q;
    EXMEM_rd         = rd_q;
    EXMEM_RegWrite   = regwrite_q;
    EXMEM_ALU_result = alu_q;
    WB_data          = wb_data_q;
    WB_rd            = wb_rd_q;
    WB_RegWrite      = wb_regwrite_q;
    misaligned       = wb_mis_q;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a reference memory model computes each slot's write-back
// result at issue time and a queue holds it until the slot reaches MEM/WB.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] ALU_result = '0, B = '0, Target = '0;
  logic        Zero = 1'b0;
  logic [4:0]  rd = '0;
  logic        Branch = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, MemtoReg = 1'b0, RegWrite = 1'b0;
  logic        PCSrc;
  logic [63:0] Branch_target, EXMEM_ALU_result, WB_data;
  logic [4:0]  EXMEM_rd, WB_rd;
  logic        EXMEM_RegWrite, WB_RegWrite, misaligned;

  ex_mem_stage #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ALU_result(ALU_result), .B(B), .Target(Target), .Zero(Zero), .rd(rd),
    .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite),
    .PCSrc(PCSrc), .Branch_target(Branch_target), .EXMEM_rd(EXMEM_rd),
    .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_ALU_result(EXMEM_ALU_result),
    .WB_data(WB_data), .WB_rd(WB_rd), .WB_RegWrite(WB_RegWrite), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
  } wb_t;

  wb_t         q[$];
  wb_t         last;
  logic [63:0] mm [256];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input wb_t e);
    check("WB_data", WB_data, e.data);
    check("WB_rd", {59'd0, WB_rd}, {59'd0, e.rd});
    check("WB_RegWrite", {63'd0, WB_RegWrite}, {63'd0, e.rw});
    check("misaligned", {63'd0, misaligned}, {63'd0, e.mis});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_PCSrc"}, {63'd0, PCSrc}, 64'd0);
    check({tag, "_Branch_target"}, Branch_target, 64'd0);
    check({tag, "_EXMEM_rd"}, {59'd0, EXMEM_rd}, 64'd0);
    check({tag, "_EXMEM_RegWrite"}, {63'd0, EXMEM_RegWrite}, 64'd0);
    check({tag, "_EXMEM_ALU_result"}, EXMEM_ALU_result, 64'd0);
    check({tag, "_WB_data"}, WB_data, 64'd0);
    check({tag, "_WB_rd"}, {59'd0, WB_rd}, 64'd0);
    check({tag, "_WB_RegWrite"}, {63'd0, WB_RegWrite}, 64'd0);
    check({tag, "_misaligned"}, {63'd0, misaligned}, 64'd0);
  endtask

  // Drive one slot for one edge; model its MEM outcome in program order and queue it.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [63:0] t,
                       input logic z, input logic [4:0] r, input logic br, input logic mr,
                       input logic mw, input logic mtr, input logic rw, input logic fl);
    wb_t         e;
    logic        m;
    logic [7:0]  ix;
    logic        cbr, cmr, cmw, cmtr, crw;
    ALU_result = a; B = b; Target = t; Zero = z; rd = r;
    Branch = br; MemRead = mr; MemWrite = mw; MemtoReg = mtr; RegWrite = rw; flush = fl;
    cbr = br & ~fl; cmr = mr & ~fl; cmw = mw & ~fl; cmtr = mtr & ~fl; crw = rw & ~fl;
    m  = (cmr | cmw) & (a[2:0] != 3'd0);
    ix = a[10:3];
    e.data = cmtr ? (m ? 64'd0 : mm[ix]) : a;
    e.rd   = r;
    e.rw   = crw & ~(cmr & m);
    e.mis  = m;
    if (cmw && !m) mm[ix] = b;
    q.push_back(e);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("EXMEM_rd", {59'd0, EXMEM_rd}, {59'd0, r});
    check("EXMEM_RegWrite", {63'd0, EXMEM_RegWrite}, {63'd0, crw});
    check("EXMEM_ALU_result", EXMEM_ALU_result, a);
    check("PCSrc", {63'd0, PCSrc}, {63'd0, cbr & z});
    check("Branch_target", Branch_target, t);
    if (q.size() > 1) begin
      last = q.pop_front();
      check_wb(last);
    end
  endtask

  task automatic nop();
    issue(64'd0, 64'd0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic alu(input logic [63:0] a, input logic [4:0] r);
    issue(a, 64'd0, 64'd0, 1'b0, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic st(input logic [63:0] a, input logic [63:0] b, input logic fl);
    issue(a, b, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, fl);
  endtask
  task automatic ld(input logic [63:0] a, input logic [4:0] r);
    issue(a, 64'd0, 64'd0, 1'b0, r, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic brn(input logic [63:0] t, input logic z);
    issue(64'd0, 64'd0, t, z, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] held_alu;
    // Reset with every input nonzero: outputs clear before any clock edge.
    ALU_result = 64'hFFFF_FFFF_FFFF_FFF8; B = 64'h1234; Target = 64'h99; Zero = 1'b1;
    rd = 5'd31; Branch = 1'b1; MemRead = 1'b1; MemWrite = 1'b1; MemtoReg = 1'b1;
    RegWrite = 1'b1; flush = 1'b0;
    #1 reset = 1'b1;
    #1 check_all_zero("rst_async");
    repeat (3) @(posedge clk);
    #1 check_all_zero("rst_held");
    reset = 1'b0;

    // ALU result forwarding and write-back
    alu(64'h14, 5'd5);
    nop();

    // Store then load of the same doubleword
    st(64'h40, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    ld(64'h40, 5'd7);
    nop();

    // Branch taken and not taken
    brn(64'h508, 1'b1);
    brn(64'h508, 1'b0);
    nop();

    // Flushed store (with a taken-branch pattern) must be a bubble
    st(64'h80, 64'h1111, 1'b0);
    issue(64'h80, 64'h2222, 64'h700, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    ld(64'h80, 5'd3);
    nop();

    // Stall two cycles with a store sitting in EX/MEM
    st(64'h100, 64'hAAAA_5555_0000_FFFF, 1'b0);
    held_alu = EXMEM_ALU_result;
    stall = 1'b1;
    ALU_result = 64'h3F8; B = 64'hBAD; MemWrite = 1'b1; RegWrite = 1'b1; rd = 5'd17;
    flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_wb(last);
      check("stall_EXMEM_ALU_result", EXMEM_ALU_result, 64'h100);
    end
    stall = 1'b0;
    flush = 1'b0;
    ld(64'h100, 5'd4);
    nop();

    // Misaligned load and store
    ld(64'h43, 5'd9);
    st(64'h45, 64'h5555, 1'b0);
    ld(64'h40, 5'd10);
    nop();

    // Index wraps modulo DEPTH
    st(64'd2048 + 64'h10, 64'h77, 1'b0);
    ld(64'h10, 5'd11);
    nop();
    nop();

    // Reset while a store is in EX/MEM: the store must never land
    ALU_result = 64'h10; B = 64'h9999; MemWrite = 1'b1; MemRead = 1'b0; MemtoReg = 1'b0;
    RegWrite = 1'b0; Branch = 1'b0; rd = 5'd0;
    @(posedge clk);
    #1;
    check("midstore_EXMEM_ALU_result", EXMEM_ALU_result, 64'h10);
    #2 reset = 1'b1;
    #1 check_all_zero("rst_midstore");
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    ld(64'h10, 5'd12);
    nop();
    if (held_alu !== 64'h100) check("stall_setup", held_alu, 64'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Memory stage of the 64-bit pipelined RISC-V core, directly downstream of Execute.
- Registers Execute outputs (ALU_result, B, Target, Zero) plus control into an EX/MEM register.
- Performs the doubleword data-memory access and resolves the branch decision.
- Registers results into a MEM/WB register for write-back, and exposes EX/MEM fields to the forwarding unit.

Parameters:
- DEPTH, 256, number of 64-bit doublewords in data memory (power of two).
- AW, 8, index width, log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold both pipeline registers; suppress memory write
- flush  in  1  insert bubble into EX/MEM (clear control bits)
- ALU_result  in  64  Execute result or effective address
- B  in  64  store data (rs2 value)
- Target  in  64  branch target from Execute
- Zero  in  1  Execute zero flag
- rd  in  5  destination register
- Branch, MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control bits from ID/EX
- PCSrc  out  1  EXMEM_Branch & EXMEM_Zero
- Branch_target  out  64  EXMEM_Target
- EXMEM_rd  out  5  forwarding
- EXMEM_RegWrite  out  1  forwarding
- EXMEM_ALU_result  out  64  forwarding
- WB_data  out  64  MEM/WB write-back value
- WB_rd  out  5  MEM/WB destination
- WB_RegWrite  out  1  MEM/WB write enable
- misaligned  out  1  MEM/WB flag: the access in this slot had addr[2:0] != 0

Behaviour:
- Reset (async, immediate): all EX/MEM and MEM/WB fields clear to 0, so every output reads 0. Memory contents are not reset.
- Pipeline edge, stall=0, flush=0: EX/MEM captures all inputs.
- Pipeline edge, stall=0, flush=1: EX/MEM captures data fields, but Branch, MemRead, MemWrite, MemtoReg and RegWrite are forced to 0.
- Pipeline edge, stall=1: EX/MEM and MEM/WB hold their values; flush is ignored; no memory write.
- Memory index: EXMEM_ALU_result[AW+2:3]. Upper address bits are ignored (wrap-around modulo DEPTH).
- mis = (EXMEM_MemRead | EXMEM_MemWrite) & (EXMEM_ALU_result[2:0] != 0).
- Write: synchronous at rising edge when EXMEM_MemWrite & ~mis & ~stall; mem[idx] <= EXMEM_B.
- Read: combinational, mem[idx]. A load directly following a store to the same index returns the stored value, because the write lands at the edge before the load is in EX/MEM.
- MEM/WB at edge, stall=0:
  - WB_data <= EXMEM_MemtoReg ? (mis ? 0 : mem[idx]) : EXMEM_ALU_result
  - WB_rd <= EXMEM_rd
  - WB_RegWrite <= EXMEM_RegWrite & ~(EXMEM_MemRead & mis)
  - misaligned <= mis
- Latency: instruction presented at edge N → PCSrc and forwarding outputs valid after N; WB_* valid after N+1.
- PCSrc and Branch_target are combinational from EX/MEM only; the block has no combinational input-to-output paths.
- Reset asserted mid-store: the write must not occur on any edge while reset=1.

Test Plan:
- Reset asserted with all inputs nonzero → every output 0 immediately, before any clock edge; held through 3 edges.
- ALU: ALU_result=0x14, rd=5, RegWrite=1, MemtoReg=0 → EXMEM_rd=5 and EXMEM_ALU_result=0x14 after edge 1; WB_data=0x14, WB_rd=5, WB_RegWrite=1 after edge 2.
- Store then load: cycle 1 store addr 0x40, B=0xDEADBEEF_CAFEF00D; cycle 2 load addr 0x40 with MemtoReg=1, rd=7 → WB_data=0xDEADBEEF_CAFEF00D, WB_rd=7 after edge 3.
- Branch: Branch=1, Zero=1, Target=0x508 → PCSrc=1, Branch_target=0x508 after edge 1. Repeat with Zero=0 → PCSrc=0.
- Flush and stall:
  - Store addr 0x80 with flush=1 → later load of 0x80 returns the prior value, and PCSrc=0.
  - stall=1 for 2 cycles with a store in EX/MEM → WB_* unchanged, single write committed only after stall drops.
- Misaligned: load addr 0x43, RegWrite=1 → misaligned=1, WB_RegWrite=0, WB_data=0. Misaligned store addr 0x45 → memory unchanged. Address DEPTH*8+0x10 aliases to 0x10.
